// File: rtl/seq_addr_core.sv
// seq_addr_core: microprogram next-address core for the sequencer datapath.
// The block selects the next address Y from one of four sources (PC, D, R, F).
// It also holds all next-address state: the microprogram counter, a loadable
// down-counter, and a LIFO subroutine/loop stack.
//
// Ports:
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   d_in         direct/branch address
//   sel          Y source: 00 PC, 01 D, 10 R, 11 F
//   ci           incrementer carry-in (pc <= y + ci)
//   r_load       load R from d_in (has priority over r_dec)
//   r_dec        decrement R (wraps from 0 to all-ones)
//   push, pop    stack control
//   stk_clr      empty the stack (highest priority)
//   y_out        combinational next address
//   pc_out       microprogram counter
//   r_out        register/counter value
//   f_out        top of stack; 0 when the stack is empty
//   r_zero       R == 0
//   full, empty  stack status
//   sp           stack occupancy
module seq_addr_core #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned STACK_DEPTH = 5,
    localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] d_in,
    input  logic [1:0]        sel,
    input  logic              ci,
    input  logic              r_load,
    input  logic              r_dec,
    input  logic              push,
    input  logic              pop,
    input  logic              stk_clr,
    output logic [ADDR_W-1:0] y_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] r_out,
    output logic [ADDR_W-1:0] f_out,
    output logic              r_zero,
    output logic              full,
    output logic              empty,
    output logic [SP_W-1:0]   sp
);

    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;

    // Status decoded straight from registers.
    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SP_FULL);
    assign r_zero  = (r_q == '0);
    assign top_idx = IDX_W'(sp_q - SP_ONE);

    assign pc_out = pc_q;
    assign r_out  = r_q;
    assign sp     = sp_q;
    assign f_out  = empty ? '0 : stack_mem[top_idx];

    // Y mux; F sees the pre-pop top so a return with pop lands on the saved address.
    always_comb begin
        y_out = pc_q;
        case (sel)
            2'b00:   y_out = pc_q;
            2'b01:   y_out = d_in;
            2'b10:   y_out = r_q;
            default: y_out = f_out;
        endcase
    end

    always_comb begin
        pc_d = y_out + ADDR_W'(ci);

        r_d = r_q;
        if (r_load) begin
            r_d = d_in;
        end else if (r_dec) begin
            r_d = r_q - ADDR_W'(1);
        end
    end

    // Stack control. A push overwrites the top (sp unchanged) when it is combined
    // with a pop on a non-empty stack, or when the stack is already full.
    always_comb begin
        sp_d   = sp_q;
        wr_en  = 1'b0;
        wr_idx = IDX_W'(sp_q);
        if (stk_clr) begin
            sp_d = '0;
        end else if (push) begin
            wr_en = 1'b1;
            if (!empty && (pop || full)) begin
                wr_idx = top_idx;
            end else begin
                wr_idx = IDX_W'(sp_q);
                sp_d   = sp_q + SP_ONE;
            end
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
            r_q  <= '0;
            sp_q <= '0;
        end else begin
            pc_q <= pc_d;
            r_q  <= r_d;
            sp_q <= sp_d;
        end
    end

    // Stack storage is deliberately not reset; the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_mem[wr_idx] <= pc_q;
        end
    end

endmodule

// File: doc/seq_addr_core.md
# seq_addr_core

Parametrised microprogram next-address core for the sequencer datapath. It combines the four-source next-address select (PC, D, R, F) with its state:
- a microprogram counter with carry-in increment;
- a loadable down-counting register/counter;
- a LIFO subroutine/loop stack with full/empty status.

External control (instruction decode) drives the explicit control inputs. This block owns all next-address state and produces the combinational Y address.

## Interface
- ADDR_W, 12: width of every address/counter path.
- STACK_DEPTH, 5: number of stack entries; must be at least 2.
- SP_W, $clog2(STACK_DEPTH+1): stack pointer width (derived, not overridden).

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- d_in  in  ADDR_W  direct/branch address input
- sel  in  2  Y source: 00 PC, 01 D, 10 R, 11 F
- ci  in  1  incrementer carry-in
- r_load  in  1  load R from d_in
- r_dec  in  1  decrement R
- push  in  1  push pc_out onto stack
- pop  in  1  pop stack
- stk_clr  in  1  empty the stack
- y_out  out  ADDR_W  selected next address (combinational)
- pc_out  out  ADDR_W  microprogram counter register
- r_out  out  ADDR_W  register/counter value
- f_out  out  ADDR_W  top-of-stack value; 0 when empty
- r_zero  out  1  R == 0 (combinational)
- full  out  1  sp == STACK_DEPTH
- empty  out  1  sp == 0
- sp  out  SP_W  current stack occupancy

## Operation
- Y mux: pc_out, d_in, r_out or f_out per sel. Purely combinational.
- uPC: every cycle pc_out <= y_out + ci, truncated to ADDR_W. All-ones + 1 wraps to 0.
- R: r_load has priority, so R <= d_in. Otherwise, if r_dec, R <= R - 1; 0 - 1 wraps to all-ones. Otherwise R holds.
- Stack, with priority stk_clr > push&pop > push > pop:
  - stk_clr: sp <= 0. Entry contents are don't-care.
  - push & pop together: top entry replaced by pc_out and sp unchanged. If empty, this acts as a plain push.
  - push when not full: entry[sp] <= pc_out, sp <= sp + 1.
  - push when full: top entry (index STACK_DEPTH-1) overwritten with pc_out, sp unchanged, full stays 1.
  - pop when not empty: sp <= sp - 1.
  - pop when empty: no effect, no error.
- f_out = entry[sp-1] when sp != 0, else 0.
- The pushed value is the pre-edge pc_out, i.e. the return address that was current this cycle.
- sel = F with a simultaneous pop: y_out uses the pre-pop top. The stack pops at the edge (return semantics).
- Status outputs (r_zero, full, empty) are decoded from registers. No extra latency.

## Timing
- Reset (asynchronous, active-high, any time, including mid-push or mid-pop):
  - pc_out = 0, R = 0, sp = 0.
  - Consequently empty = 1, full = 0, r_zero = 1, f_out = 0.
  - y_out follows sel over the reset values.
  - Stack RAM contents are not reset.
- Deassertion: the first rising edge after rst falls updates state normally.
- y_out to pc_out: 1 cycle. y_out is valid combinationally in the same cycle as sel/d_in change.
- push/pop/r_load/r_dec take effect at the next rising edge. Outputs reflect them in the following cycle.
- No handshake. Every control input is sampled every cycle, with no stall or hold state.

## Test plan
- Reset, then ci = 1, sel = PC held for 4 cycles → pc_out reads 0, 1, 2, 3, 4. With ci = 0 it holds.
- Jump and wrap: sel = D, d_in = 0xFFF, ci = 1 → y_out = 0xFFF immediately; pc_out = 0x000 the next cycle.
- Counter: r_load with d_in = 2, then r_dec for 3 cycles → r_out reads 2, 1, 0, 0xFFF; r_zero = 1 only at 0. r_load & r_dec in the same cycle with d_in = 7 → r_out = 7.
- Stack fill and overflow with STACK_DEPTH = 5: push 6 times with pc_out = 0x10..0x15.
  - sp climbs 1..5; full = 1 after the 5th push.
  - The 6th push overwrites the top: f_out = 0x15, sp = 5.
  - Pop 5 times → f_out reads 0x13, 0x12, 0x11, 0x10, 0; empty = 1.
  - A 6th pop leaves sp = 0.
- Return: push 0x20, then sel = F with pop and ci = 0 → y_out = 0x20 that cycle; next cycle pc_out = 0x20, sp = 0. Also cover push & pop together with sp = 2 → top replaced and sp stays 2.
- Async reset mid-operation: assert rst between edges with sp = 3 and R = 5 → immediately sp = 0, empty = 1, r_out = 0, pc_out = 0, without waiting for a clock edge. stk_clr asserted with push → sp = 0.
